// File: rtl/clock_divide_multi.sv
// Multi-channel programmable clock divider: each channel's frequency in Hz is turned into a
// half-period count by one shared restoring divider, driving a 50% square wave and a rising-edge tick.
module clock_divide_multi #(
    parameter int CLK_HZ = 50_000_000,
    parameter int NUM_CH = 4,
    parameter int FREQ_W = 24,
    parameter int CNT_W  = 32
) (
    input  logic                     clk_in,
    input  logic                     rst,
    input  logic [NUM_CH*FREQ_W-1:0] freq,
    input  logic [NUM_CH-1:0]        load,
    input  logic [NUM_CH-1:0]        enable,
    output logic [NUM_CH-1:0]        clk_div,
    output logic [NUM_CH-1:0]        tick,
    output logic                     busy
);
    localparam int DW = (FREQ_W + 1 > CNT_W + 1) ? FREQ_W + 1 : CNT_W + 1;
    localparam int SW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int BW = $clog2(CNT_W + 1);

    typedef enum logic [1:0] {IDLE, START, DIV, WB} state_t;
    state_t state, state_next;

    logic [FREQ_W-1:0] freq_latch [NUM_CH];
    logic [NUM_CH-1:0] pend, pend_next, clr;
    logic [SW-1:0]     sel, pick;
    logic              pick_valid;
    logic              take, do_start, do_step, do_wb;
    logic [DW-1:0]     divisor, rem;
    logic [CNT_W-1:0]  quo, wb_half;
    logic [BW-1:0]     bit_cnt;
    logic [DW:0]       trial, diff;
    logic              ge;
    logic [CNT_W-1:0]  half [NUM_CH];
    logic [CNT_W-1:0]  cnt  [NUM_CH];

    always_comb begin
        pick       = '0;
        pick_valid = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (pend[i]) begin
                pick       = SW'(i);
                pick_valid = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (pick_valid) state_next = START;
            START:   state_next = DIV;
            DIV:     if (bit_cnt == BW'(CNT_W - 1)) state_next = WB;
            WB:      state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        take     = (state == IDLE) && pick_valid;
        do_start = (state == START);
        do_step  = (state == DIV);
        do_wb    = (state == WB);
    end

    // A load arriving on the same cycle its channel is picked stays pending.
    always_comb begin
        clr       = take ? (NUM_CH'(1) << pick) : '0;
        pend_next = (pend & ~clr) | load;
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            pend <= '0;
            sel  <= '0;
            busy <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) freq_latch[i] <= '0;
        end else begin
            pend <= pend_next;
            busy <= (pend_next != '0) || (state_next != IDLE);
            if (take) sel <= pick;
            for (int i = 0; i < NUM_CH; i++) begin
                if (load[i]) freq_latch[i] <= freq[i*FREQ_W +: FREQ_W];
            end
        end
    end

    always_comb begin
        trial = {rem, quo[CNT_W-1]};
        ge    = trial >= {1'b0, divisor};
        diff  = trial - {1'b0, divisor};
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            rem     <= '0;
            quo     <= '0;
            divisor <= '0;
            bit_cnt <= '0;
        end else if (do_start) begin
            rem     <= '0;
            quo     <= CNT_W'(CLK_HZ);
            divisor <= DW'(freq_latch[sel]) << 1;
            bit_cnt <= '0;
        end else if (do_step) begin
            rem     <= ge ? diff[DW-1:0] : trial[DW-1:0];
            quo     <= {quo[CNT_W-2:0], ge};
            bit_cnt <= bit_cnt + 1'b1;
        end
    end

    // The zero test uses the captured divisor, so a reload mid-division cannot change this result.
    always_comb begin
        if (divisor == '0)     wb_half = '0;
        else if (quo == '0)    wb_half = CNT_W'(1);
        else                   wb_half = quo;
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            clk_div <= '0;
            tick    <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                half[i] <= '0;
                cnt[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (do_wb && sel == SW'(i)) begin
                    half[i]    <= wb_half;
                    cnt[i]     <= '0;
                    clk_div[i] <= 1'b0;
                    tick[i]    <= 1'b0;
                end else if (half[i] == '0) begin
                    cnt[i]     <= '0;
                    clk_div[i] <= 1'b0;
                    tick[i]    <= 1'b0;
                end else if (!enable[i]) begin
                    tick[i]    <= 1'b0;
                end else if (cnt[i] == half[i] - 1'b1) begin
                    cnt[i]     <= '0;
                    clk_div[i] <= ~clk_div[i];
                    tick[i]    <= ~clk_div[i];
                end else begin
                    cnt[i]     <= cnt[i] + 1'b1;
                    tick[i]    <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_clock_divide_multi.sv
// Directed bench for clock_divide_multi with CLK_HZ=1000, CNT_W=16: table of single-channel
// retunes plus hand sequences for dual loads, enable freeze, zero frequency and mid-division reset.
module tb_clock_divide_multi;
    localparam int CLK_HZ = 1000;
    localparam int NUM_CH = 4;
    localparam int FREQ_W = 16;
    localparam int CNT_W  = 16;

    logic                     clk;
    logic                     rst;
    logic [NUM_CH*FREQ_W-1:0] freq;
    logic [NUM_CH-1:0]        load;
    logic [NUM_CH-1:0]        enable;
    logic [NUM_CH-1:0]        clk_div;
    logic [NUM_CH-1:0]        tick;
    logic                     busy;

    int tests_run;
    int tests_failed;

    typedef struct {
        int ch;
        int f;
        int half;
    } vec_t;

    vec_t vecs [8];

    clock_divide_multi #(
        .CLK_HZ(CLK_HZ),
        .NUM_CH(NUM_CH),
        .FREQ_W(FREQ_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk_in (clk),
        .rst    (rst),
        .freq   (freq),
        .load   (load),
        .enable (enable),
        .clk_div(clk_div),
        .tick   (tick),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests_run++;
        if (actual != expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Drives one load pulse; returns at the negedge just after the capturing edge.
    task automatic applyStimulus(input logic [NUM_CH-1:0] mask, input int f0, input int f1);
        @(negedge clk);
        for (int i = 0; i < NUM_CH; i++) begin
            if (mask[i]) freq[i*FREQ_W +: FREQ_W] = (i == 0 || f1 < 0) ? FREQ_W'(f0) : FREQ_W'(f1);
        end
        load = mask;
        @(negedge clk);
        load = '0;
    endtask

    task automatic countBusy(output int n);
        n = 0;
        while (busy && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic runLength(input int ch, input logic level, output int n, output int ticks,
                             output int first_tick);
        n = 0;
        ticks = 0;
        first_tick = int'(tick[ch]);
        while (clk_div[ch] == level && n < 3000) begin
            n++;
            ticks += int'(tick[ch]);
            @(negedge clk);
        end
    endtask

    task automatic measurePeriod(input int ch, input int exp_half, input string tag);
        int n, t, ft, h, l, th, tl;
        if (clk_div[ch]) runLength(ch, 1'b1, n, t, ft);
        runLength(ch, 1'b0, n, t, ft);
        runLength(ch, 1'b1, h, th, ft);
        runLength(ch, 1'b0, l, tl, n);
        checkOutput({tag, " high_len"}, h, exp_half);
        checkOutput({tag, " low_len"}, l, exp_half);
        checkOutput({tag, " ticks_per_period"}, th + tl, 1);
        checkOutput({tag, " tick_on_first_high"}, ft, 1);
    endtask

    initial begin
        int n, t, ft, h, l, th, tl, hi, tk;
        string tag;

        tests_run    = 0;
        tests_failed = 0;
        rst    = 1'b1;
        freq   = '0;
        load   = '0;
        enable = '1;

        vecs[0] = '{ch: 0, f: 1,   half: 500};
        vecs[1] = '{ch: 1, f: 250, half: 2};
        vecs[2] = '{ch: 1, f: 600, half: 1};
        vecs[3] = '{ch: 2, f: 3,   half: 166};
        vecs[4] = '{ch: 3, f: 100, half: 5};
        vecs[5] = '{ch: 2, f: 500, half: 1};
        vecs[6] = '{ch: 0, f: 7,   half: 71};
        vecs[7] = '{ch: 1, f: 9,   half: 55};

        repeat (3) @(negedge clk);
        checkOutput("reset clk_div", int'(clk_div), 0);
        checkOutput("reset tick", int'(tick), 0);
        checkOutput("reset busy", int'(busy), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // One pending cycle, then START + CNT_W DIV + WB before busy drops.
        for (int v = 0; v < 8; v++) begin
            tag = $sformatf("vec%0d ch%0d f=%0d", v, vecs[v].ch, vecs[v].f);
            applyStimulus(NUM_CH'(1) << vecs[v].ch, vecs[v].f, vecs[v].f);
            countBusy(n);
            checkOutput({tag, " busy_cycles"}, n, CNT_W + 3);
            runLength(vecs[v].ch, 1'b0, l, tl, ft);
            runLength(vecs[v].ch, 1'b1, h, th, ft);
            checkOutput({tag, " restart_low_len"}, l, vecs[v].half);
            checkOutput({tag, " high_len"}, h, vecs[v].half);
            checkOutput({tag, " tick_on_first_high"}, ft, 1);
            runLength(vecs[v].ch, 1'b0, l, tl, n);
            checkOutput({tag, " low_len"}, l, vecs[v].half);
            checkOutput({tag, " ticks_per_period"}, th + tl, 1);
        end

        // Same-cycle loads: ch0 served first, ch2 after an IDLE cycle, busy never drops.
        applyStimulus(4'b0101, 100, 50);
        countBusy(n);
        checkOutput("dual busy_cycles", n, 2 * (CNT_W + 2) + 2);
        runLength(2, 1'b0, l, tl, ft);
        checkOutput("dual ch2 restart_low_len", l, 10);
        measurePeriod(2, 10, "dual ch2");
        measurePeriod(0, 5, "dual ch0");

        // Freeze ch3 for seven edges in the middle of its high phase.
        if (clk_div[3]) runLength(3, 1'b1, n, t, ft);
        runLength(3, 1'b0, n, t, ft);
        hi = 0;
        tk = 0;
        while (clk_div[3] && hi < 100) begin
            hi++;
            tk += int'(tick[3]);
            if (hi == 2) enable[3] = 1'b0;
            if (hi == 9) enable[3] = 1'b1;
            @(negedge clk);
        end
        enable[3] = 1'b1;
        checkOutput("freeze ch3 high_len", hi, 5 + 7);
        checkOutput("freeze ch3 ticks", tk, 1);
        runLength(3, 1'b0, l, tl, ft);
        checkOutput("freeze ch3 next_low_len", l, 5);

        applyStimulus(4'b0001, 0, 0);
        countBusy(n);
        checkOutput("zero busy_cycles", n, CNT_W + 3);
        h = 0;
        th = 0;
        for (int c = 0; c < 300; c++) begin
            h  += int'(clk_div[0]);
            th += int'(tick[0]);
            @(negedge clk);
        end
        checkOutput("zero ch0 high_samples", h, 0);
        checkOutput("zero ch0 ticks", th, 0);
        measurePeriod(3, 5, "after zero ch3");

        // Reset lands on the eighth DIV cycle of a ch1 computation.
        applyStimulus(4'b0010, 50, 50);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midreset clk_div", int'(clk_div), 0);
        checkOutput("midreset tick", int'(tick), 0);
        checkOutput("midreset busy", int'(busy), 0);
        h = 0;
        th = 0;
        for (int c = 0; c < 100; c++) begin
            h  += int'(clk_div != '0) + int'(busy);
            th += int'(tick != '0);
            @(negedge clk);
        end
        checkOutput("midreset no_writeback", h, 0);
        checkOutput("midreset no_ticks", th, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
